// File: rtl/ror_pkg.sv
// rtl/ror_pkg.sv - shared state type, parameter defaults and batch-count helper for the ROR sequencer
package ror_pkg;

  localparam int          N_DEF         = 16;
  localparam int          M_DEF         = 32;
  localparam int          AW_DEF        = 15;
  localparam int          CORE_LAT_DEF  = 1;
  localparam logic [15:0] PAD_COORD_DEF = 16'h7FFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_PT,
    S_LOAD_PT,
    S_FETCH_BT,
    S_LOAD_BT,
    S_EVAL,
    S_EMIT,
    S_NEXT,
    S_FIN
  } ror_state_t;

  // Number of M-wide batches needed to cover a cloud of 'size' points.
  function automatic int unsigned batch_count(input int unsigned size, input int unsigned m);
    return (size + m - 1) / m;
  endfunction

endpackage

// File: rtl/ror_batch_pad.sv
// rtl/ror_batch_pad.sv - replaces batch slots lying past the end of the cloud with the pad coordinate
module ror_batch_pad
  import ror_pkg::*;
#(
  parameter int         N         = N_DEF,
  parameter int         M         = M_DEF,
  parameter int         AW        = AW_DEF,
  parameter logic [N-1:0] PAD_COORD = N'(PAD_COORD_DEF)
) (
  input  logic [AW-1:0]  i_bidx,
  input  logic [AW:0]    i_cloud_size,
  input  logic [N*M-1:0] i_x,
  input  logic [N*M-1:0] i_y,
  input  logic [N*M-1:0] i_z,
  output logic [N*M-1:0] o_x,
  output logic [N*M-1:0] o_y,
  output logic [N*M-1:0] o_z
);

  // Wide enough for the largest point index a batch can name, plus headroom.
  localparam int PW = AW + $clog2(M) + 1;

  logic [PW-1:0] w_base;

  assign w_base = PW'(i_bidx) * PW'(M);

  // Slot s (slot 0 in the MSBs) holds point w_base+s; at or past cloud_size it is padded on all axes.
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    for (int s = 0; s < M; s++) begin
      if (w_base + PW'(s) >= PW'(i_cloud_size)) begin
        o_x[N*(M-s)-1 -: N] = PAD_COORD;
        o_y[N*(M-s)-1 -: N] = PAD_COORD;
        o_z[N*(M-s)-1 -: N] = PAD_COORD;
      end
    end
  end

endmodule

// File: rtl/ror_sequencer.sv
// rtl/ror_sequencer.sv - per-point fetch / batch-stream / verdict / emit sequencer around validator_core
module ror_sequencer
  import ror_pkg::*;
#(
  parameter int           N         = N_DEF,
  parameter int           M         = M_DEF,
  parameter int           AW        = AW_DEF,
  parameter int           CORE_LAT  = CORE_LAT_DEF,
  parameter logic [N-1:0] PAD_COORD = N'(PAD_COORD_DEF)
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [AW:0]    i_cloud_size,
  output logic           o_busy,
  output logic           o_done,
  output logic [AW-1:0]  o_pt_addr,
  output logic           o_pt_rd,
  input  logic [3*N-1:0] i_pt_data,
  output logic [AW-1:0]  o_bt_addr,
  output logic           o_bt_rd,
  input  logic [N*M-1:0] i_bt_x,
  input  logic [N*M-1:0] i_bt_y,
  input  logic [N*M-1:0] i_bt_z,
  output logic           o_core_reset,
  output logic [N-1:0]   o_core_px,
  output logic [N-1:0]   o_core_py,
  output logic [N-1:0]   o_core_pz,
  output logic [N*M-1:0] o_core_cp_x,
  output logic [N*M-1:0] o_core_cp_y,
  output logic [N*M-1:0] o_core_cp_z,
  input  logic           i_core_inlier,
  input  logic           i_core_outlier,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [N-1:0]   o_out_x,
  output logic [N-1:0]   o_out_y,
  output logic [N-1:0]   o_out_z,
  output logic [AW:0]    o_n_inlier,
  output logic [AW:0]    o_n_outlier
);

  localparam int LW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  ror_state_t     r_state, w_next;
  logic [AW:0]    r_size;
  logic [AW-1:0]  r_idx;
  logic [AW-1:0]  r_bidx;
  logic [AW-1:0]  r_last;
  logic [LW-1:0]  r_lat;
  logic           r_is_in;
  logic           r_done;
  logic [N-1:0]   r_px, r_py, r_pz;
  logic [N*M-1:0] r_cpx, r_cpy, r_cpz;
  logic [AW:0]    r_nin, r_nout;
  logic [N*M-1:0] w_pad_x, w_pad_y, w_pad_z;

  ror_batch_pad #(
    .N         (N),
    .M         (M),
    .AW        (AW),
    .PAD_COORD (PAD_COORD)
  ) u_pad (
    .i_bidx       (r_bidx),
    .i_cloud_size (r_size),
    .i_x          (i_bt_x),
    .i_y          (i_bt_y),
    .i_z          (i_bt_z),
    .o_x          (w_pad_x),
    .o_y          (w_pad_y),
    .o_z          (w_pad_z)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and strobe decode; the verdict is sampled on the CORE_LAT-th edge after core_cp_* loads.
  always_comb begin
    w_next       = r_state;
    o_pt_rd      = 1'b0;
    o_bt_rd      = 1'b0;
    o_core_reset = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_core_reset = 1'b1;
        if (i_start) w_next = (i_cloud_size == '0) ? S_FIN : S_FETCH_PT;
      end
      S_FETCH_PT: begin
        o_pt_rd = 1'b1;
        w_next  = S_LOAD_PT;
      end
      S_LOAD_PT: begin
        o_core_reset = 1'b1;
        w_next       = S_FETCH_BT;
      end
      S_FETCH_BT: begin
        o_bt_rd = 1'b1;
        w_next  = S_LOAD_BT;
      end
      S_LOAD_BT: w_next = S_EVAL;
      S_EVAL: begin
        if (r_lat == '0) begin
          if (i_core_inlier)                         w_next = S_EMIT;
          else if (i_core_outlier || r_bidx == r_last) w_next = S_NEXT;
          else                                       w_next = S_FETCH_BT;
        end
      end
      S_EMIT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_NEXT;
      end
      S_NEXT: w_next = (({1'b0, r_idx} + (AW+1)'(1)) == r_size) ? S_FIN : S_FETCH_PT;
      S_FIN: begin
        o_core_reset = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pass bookkeeping, core operand registers and verdict counters; core inputs only move on load states.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_size  <= '0;
      r_idx   <= '0;
      r_bidx  <= '0;
      r_last  <= '0;
      r_lat   <= '0;
      r_is_in <= 1'b0;
      r_done  <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_pz    <= '0;
      r_cpx   <= '0;
      r_cpy   <= '0;
      r_cpz   <= '0;
      r_nin   <= '0;
      r_nout  <= '0;
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_size <= i_cloud_size;
            r_idx  <= '0;
            r_nin  <= '0;
            r_nout <= '0;
            r_last <= AW'(batch_count(32'(i_cloud_size), unsigned'(M)) - 1);
          end
        end
        S_LOAD_PT: begin
          r_px   <= i_pt_data[3*N-1 -: N];
          r_py   <= i_pt_data[2*N-1 -: N];
          r_pz   <= i_pt_data[N-1:0];
          r_bidx <= '0;
        end
        S_LOAD_BT: begin
          r_cpx <= w_pad_x;
          r_cpy <= w_pad_y;
          r_cpz <= w_pad_z;
          r_lat <= LW'(CORE_LAT - 1);
        end
        S_EVAL: begin
          if (r_lat != '0) begin
            r_lat <= r_lat - LW'(1);
          end else begin
            r_is_in <= i_core_inlier;
            if (w_next == S_FETCH_BT) r_bidx <= r_bidx + AW'(1);
          end
        end
        S_NEXT: begin
          if (r_is_in) r_nin  <= r_nin + (AW+1)'(1);
          else         r_nout <= r_nout + (AW+1)'(1);
          if (w_next == S_FETCH_PT) r_idx <= r_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_pt_addr   = r_idx;
  assign o_bt_addr   = r_bidx;
  assign o_core_px   = r_px;
  assign o_core_py   = r_py;
  assign o_core_pz   = r_pz;
  assign o_core_cp_x = r_cpx;
  assign o_core_cp_y = r_cpy;
  assign o_core_cp_z = r_cpz;
  assign o_out_x     = r_px;
  assign o_out_y     = r_py;
  assign o_out_z     = r_pz;
  assign o_n_inlier  = r_nin;
  assign o_n_outlier = r_nout;

endmodule

// File: tb/tb_ror_sequencer.sv
// tb/tb_ror_sequencer.sv - self-checking bench for ror_sequencer with RAM and core models
module tb_ror_sequencer;

  localparam int N  = 16;
  localparam int M  = 32;
  localparam int AW = 15;

  localparam int MD_IN   = 0;
  localparam int MD_NONE = 1;
  localparam int MD_BOTH = 2;
  localparam int MD_PAT  = 3;

  logic           clk = 1'b0;
  logic           rst_n, start, out_ready;
  logic [AW:0]    cloud_size;
  logic           busy, done, pt_rd, bt_rd, core_reset, core_inlier, core_outlier, out_valid;
  logic [AW-1:0]  pt_addr, bt_addr;
  logic [3*N-1:0] pt_data;
  logic [N*M-1:0] bt_x, bt_y, bt_z, core_cp_x, core_cp_y, core_cp_z;
  logic [N-1:0]   core_px, core_py, core_pz, out_x, out_y, out_z;
  logic [AW:0]    n_inlier, n_outlier;

  int n_cmp, n_bad;
  int core_mode;
  bit mon_en;
  int exp_pt_q[$];
  int exp_bt_q[$];
  logic [3*N-1:0] exp_out_q[$];
  int exp_size, exp_nin, exp_nout;
  int cur_pt, cp_cnt, cp_b, bt_cnt, done_cnt, stall_cnt;
  logic prev_stall;
  logic [3*N-1:0] prev_out;
  logic [N*M-1:0] last_cp1_x;

  always #5 clk = ~clk;

  ror_sequencer dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_cloud_size(cloud_size),
    .o_busy(busy), .o_done(done), .o_pt_addr(pt_addr), .o_pt_rd(pt_rd), .i_pt_data(pt_data),
    .o_bt_addr(bt_addr), .o_bt_rd(bt_rd), .i_bt_x(bt_x), .i_bt_y(bt_y), .i_bt_z(bt_z),
    .o_core_reset(core_reset), .o_core_px(core_px), .o_core_py(core_py), .o_core_pz(core_pz),
    .o_core_cp_x(core_cp_x), .o_core_cp_y(core_cp_y), .o_core_cp_z(core_cp_z),
    .i_core_inlier(core_inlier), .i_core_outlier(core_outlier),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_x(out_x), .o_out_y(out_y), .o_out_z(out_z),
    .o_n_inlier(n_inlier), .o_n_outlier(n_outlier)
  );

  function automatic logic [N-1:0] coord(input int axis, input int a);
    logic [N-1:0] av;
    av = a[N-1:0];
    case (axis)
      0:       return 16'h1000 + av;
      1:       return 16'h2000 + av * 16'd3;
      default: return 16'h3000 ^ av;
    endcase
  endfunction

  function automatic logic [3*N-1:0] point(input int a);
    return {coord(0, a), coord(1, a), coord(2, a)};
  endfunction

  function automatic logic [N*M-1:0] exp_batch(input int axis, input int b, input int size);
    logic [N*M-1:0] v;
    for (int s = 0; s < M; s++)
      v[N*(M-s)-1 -: N] = (b*M + s >= size) ? 16'h7FFF : coord(axis, b*M + s);
    return v;
  endfunction

  // 1 = inlier, 2 = outlier, 0 = core never answers
  function automatic int verdict(input int i, input int mode);
    case (mode)
      MD_IN, MD_BOTH: return 1;
      MD_NONE:        return 0;
      default:        return (i % 4 == 0) ? 1 : ((i % 4 == 1) ? 2 : 0);
    endcase
  endfunction

  // Cloud RAMs: registered reads, batch RAM holds real points even past cloud_size.
  always @(posedge clk) begin
    if (pt_rd) pt_data <= point(int'(pt_addr));
    if (bt_rd) begin
      for (int s = 0; s < M; s++) begin
        bt_x[N*(M-s)-1 -: N] <= coord(0, int'(bt_addr) * M + s);
        bt_y[N*(M-s)-1 -: N] <= coord(1, int'(bt_addr) * M + s);
        bt_z[N*(M-s)-1 -: N] <= coord(2, int'(bt_addr) * M + s);
      end
    end
  end

  assign core_inlier  = (core_mode == MD_IN) || (core_mode == MD_BOTH) ||
                        (core_mode == MD_PAT && core_px[1:0] == 2'd0);
  assign core_outlier = (core_mode == MD_BOTH) || (core_mode == MD_PAT && core_px[1:0] == 2'd1);

  task automatic chk(input string name, input logic [N*M-1:0] act, input logic [N*M-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s act=unexpected exp=none", name);
  endtask

  // Per-cycle compare of the DUT against the expected-event queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cp_cnt     = 0;
        prev_stall = 1'b0;
      end else begin
        if (cp_cnt > 0) begin
          cp_cnt--;
          if (cp_cnt == 0) begin
            chk("core_cp_x", core_cp_x, exp_batch(0, cp_b, exp_size));
            chk("core_cp_y", core_cp_y, exp_batch(1, cp_b, exp_size));
            chk("core_cp_z", core_cp_z, exp_batch(2, cp_b, exp_size));
            chk("core_p", {core_px, core_py, core_pz}, point(cur_pt));
            if (cp_b == 1) last_cp1_x = core_cp_x;
          end
        end
        if (pt_rd) begin
          if (exp_pt_q.size() == 0) extra("pt_rd_extra");
          else begin
            cur_pt = exp_pt_q.pop_front();
            chk("pt_addr", pt_addr, cur_pt);
          end
        end
        if (bt_rd) begin
          bt_cnt++;
          if (exp_bt_q.size() == 0) extra("bt_rd_extra");
          else begin
            cp_b = exp_bt_q.pop_front();
            chk("bt_addr", bt_addr, cp_b);
            cp_cnt = 2;
          end
        end
        if (prev_stall) begin
          chk("emit_valid_hold", out_valid, 1);
          chk("emit_data_hold", {out_x, out_y, out_z}, prev_out);
        end
        if (out_valid && !out_ready) begin
          stall_cnt++;
          chk("emit_no_rd", {pt_rd, bt_rd}, 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_x, out_y, out_z};
        if (out_valid && out_ready) begin
          if (exp_out_q.size() == 0) extra("out_extra");
          else chk("out_xyz", {out_x, out_y, out_z}, exp_out_q.pop_front());
        end
        if (done) begin
          done_cnt++;
          chk("done_n_inlier", n_inlier, exp_nin);
          chk("done_n_outlier", n_outlier, exp_nout);
          chk("done_busy", busy, 0);
          chk("done_core_reset", core_reset, 1);
        end
      end
    end
  end

  task automatic build_model(input int size, input int mode);
    int nb;
    core_mode = mode;
    exp_size  = size;
    exp_nin   = 0;
    exp_nout  = 0;
    nb        = (size + M - 1) / M;
    for (int i = 0; i < size; i++) begin
      exp_pt_q.push_back(i);
      case (verdict(i, mode))
        1: begin exp_nin++; exp_out_q.push_back(point(i)); exp_bt_q.push_back(0); end
        2: begin exp_nout++; exp_bt_q.push_back(0); end
        default: begin
          exp_nout++;
          for (int b = 0; b < nb; b++) exp_bt_q.push_back(b);
        end
      endcase
    end
    bt_cnt   = 0;
    done_cnt = 0;
  endtask

  // Runs one pass from posedge+1 and returns at posedge+1 after done has been observed.
  task automatic run_pass(input int size, input int mode, input int exp_lat, input int exp_bt);
    int cyc;
    build_model(size, mode);
    cloud_size = (AW+1)'(size);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) extra("pass_timeout");
    else if (exp_lat >= 0) chk("done_latency", cyc, exp_lat);
    @(negedge clk);
    @(posedge clk); #1;
    chk("pass_done_count", done_cnt, 1);
    if (exp_bt >= 0) chk("bt_rd_count", bt_cnt, exp_bt);
    chk("left_pt", exp_pt_q.size(), 0);
    chk("left_bt", exp_bt_q.size(), 0);
    chk("left_out", exp_out_q.size(), 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pt_rd"}, pt_rd, 0);
    chk({tag, "_bt_rd"}, bt_rd, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_n_inlier"}, n_inlier, 0);
    chk({tag, "_n_outlier"}, n_outlier, 0);
    chk({tag, "_pt_addr"}, pt_addr, 0);
    chk({tag, "_core_p"}, {core_px, core_py, core_pz}, 0);
    chk({tag, "_core_cp_x"}, core_cp_x, 0);
    chk({tag, "_out_x"}, out_x, 0);
  endtask

  initial begin
    int w, cnt, cyc;
    logic [N*M-1:0] slots;
    logic [N-1:0] s7, s8;
    n_cmp = 0; n_bad = 0; mon_en = 1'b0; rst_n = 1'b0; start = 1'b0;
    cloud_size = '0; out_ready = 1'b1; core_mode = MD_IN; stall_cnt = 0;
    cur_pt = 0; cp_cnt = 0; prev_stall = 1'b0; last_cp1_x = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    rst_n = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    // Empty cloud: done two cycles after start, no batch reads, counts 0/0.
    run_pass(0, MD_NONE, 2, 0);
    chk("t1_n_inlier", n_inlier, 0);
    chk("t1_n_outlier", n_outlier, 0);

    // Single point, single batch, no verdict: 6 cycles for the point plus FIN and done.
    run_pass(1, MD_NONE, 8, 1);
    chk("t1b_n_outlier", n_outlier, 1);

    // Inlier on batch 0 for every point.
    run_pass(40, MD_IN, -1, 40);
    chk("t2_n_inlier", n_inlier, 40);
    chk("t2_n_outlier", n_outlier, 0);

    // Never answers: both batches per point, tail of batch 1 padded.
    run_pass(40, MD_NONE, -1, 80);
    chk("t3_n_inlier", n_inlier, 0);
    chk("t3_n_outlier", n_outlier, 40);
    slots = last_cp1_x;
    s7 = slots[N*(M-7)-1 -: N];
    s8 = slots[N*(M-8)-1 -: N];
    chk("t3_slot7_x", s7, 16'h1027);
    chk("t3_slot8_x", s8, 16'h7FFF);

    // Both flags together count as inlier.
    run_pass(4, MD_BOTH, -1, 4);
    chk("t4_n_inlier", n_inlier, 4);
    chk("t4_n_outlier", n_outlier, 0);

    // Mixed verdicts: i%4==0 inlier, i%4==1 outlier, otherwise exhausted.
    run_pass(40, MD_PAT, -1, 60);
    chk("tp_n_inlier", n_inlier, 10);
    chk("tp_n_outlier", n_outlier, 30);

    // Sink stalls the first emitted point for 10 cycles.
    out_ready = 1'b0;
    stall_cnt = 0;
    fork
      run_pass(3, MD_IN, -1, 3);
      begin
        w = 0;
        while (!out_valid && w < 500) begin
          @(posedge clk); #1;
          w++;
        end
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("t5_stall_cycles", stall_cnt, 10);
    chk("t5_n_inlier", n_inlier, 3);

    // Reset while the fourth point is in EVAL, then a clean 5-point pass.
    build_model(40, MD_NONE);
    cloud_size = 16'd40;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = pt_rd ? 1 : 0;
    cyc = 0;
    while (cyc < 2000 && !(cnt >= 4 && bt_rd)) begin
      @(posedge clk); #1;
      cyc++;
      if (pt_rd) cnt++;
    end
    if (!(cnt >= 4 && bt_rd)) extra("t6_reach_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_n_outlier", n_outlier, 3);
    chk("t6_pre_busy", busy, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1 chk_reset_outputs("t6");
    exp_pt_q.delete();
    exp_bt_q.delete();
    exp_out_q.delete();
    cur_pt = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    run_pass(5, MD_IN, -1, 5);
    chk("t6_n_inlier", n_inlier, 5);
    chk("t6_n_outlier", n_outlier, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
